shift_reg_multi: RTL

Parametrised multi-mode shift register: the next generation of the team's basic single-direction shift register. Each stage carries a valid flag, and the block adds forward/reverse shift, rotate and parallel load, plus a runtime-selectable tap, an occupancy count and a synchronous clear. It sits in datapaths as a programmable delay line, reorder buffer or serial/parallel converter.

---
 rtl/shift_reg_pkg.sv | 20 ++
 rtl/shift_reg_popcnt.sv | 20 ++
 rtl/shift_reg_multi.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and width helpers for the multi-mode shift register family.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        SHIFT_FWD = 2'b00,
        SHIFT_REV = 2'b01,
        ROT_FWD   = 2'b10,
        LOAD      = 2'b11
    } mode_e;

    // Tap select needs at least one bit even for a single addressable stage.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_reg_popcnt.sv
// Population count of an N-bit vector; result wide enough to hold N.
module shift_reg_popcnt
    import shift_reg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]             bits_i,
    output logic [$clog2(N+1)-1:0]   cnt_o
);

    localparam int CW = cnt_width(N);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/shift_reg_multi.sv
// Multi-mode shift register with per-stage valid flags: forward/reverse shift,
// rotate, parallel load, runtime tap, occupancy count and synchronous clear.
module shift_reg_multi
    import shift_reg_pkg::*;
#(
    parameter  int Width = 8,
    parameter  int Size  = 3,
    localparam int SelW  = sel_width(Size),
    localparam int CntW  = cnt_width(Size)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [1:0]              mode_i,
    input  logic [Width-1:0]        data_i,
    input  logic                    valid_i,
    input  logic [Width*Size-1:0]   load_i,
    input  logic [SelW-1:0]         tap_sel_i,
    output logic [Width-1:0]        data_o,
    output logic                    valid_o,
    output logic [Width-1:0]        head_o,
    output logic                    head_valid_o,
    output logic [Width-1:0]        tap_o,
    output logic                    tap_valid_o,
    output logic [CntW-1:0]         count_o,
    output logic                    full_o
);

    logic [Width*Size-1:0] stg_q, stg_d;
    logic [Size-1:0]       vld_q, vld_d;
    mode_e                 mode;

    assign mode = mode_e'(mode_i);

    // Stage k lives at stg[k*Width +: Width]; stage 0 is the head.
    always_comb begin
        stg_d = stg_q;
        vld_d = vld_q;
        if (clr_i) begin
            stg_d = '0;
            vld_d = '0;
        end else if (en_i) begin
            case (mode)
                SHIFT_FWD: begin
                    stg_d = {stg_q[Width*(Size-1)-1:0], data_i};
                    vld_d = {vld_q[Size-2:0], valid_i};
                end
                SHIFT_REV: begin
                    stg_d = {data_i, stg_q[Width*Size-1:Width]};
                    vld_d = {valid_i, vld_q[Size-1:1]};
                end
                ROT_FWD: begin
                    stg_d = {stg_q[Width*(Size-1)-1:0], stg_q[Width*Size-1 -: Width]};
                    vld_d = {vld_q[Size-2:0], vld_q[Size-1]};
                end
                LOAD: begin
                    stg_d = load_i;
                    vld_d = '1;
                end
                default: begin
                    stg_d = stg_q;
                    vld_d = vld_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q <= '0;
            vld_q <= '0;
        end else begin
            stg_q <= stg_d;
            vld_q <= vld_d;
        end
    end

    assign data_o       = stg_q[Width*Size-1 -: Width];
    assign valid_o      = vld_q[Size-1];
    assign head_o       = stg_q[Width-1:0];
    assign head_valid_o = vld_q[0];

    // Out-of-range selects (non-power-of-2 Size) match no stage and read as zero.
    always_comb begin
        tap_o       = '0;
        tap_valid_o = 1'b0;
        for (int k = 0; k < Size; k++) begin
            if (tap_sel_i == SelW'(k)) begin
                tap_o       = stg_q[k*Width +: Width];
                tap_valid_o = vld_q[k];
            end
        end
    end

    shift_reg_popcnt #(
        .N (Size)
    ) u_popcnt (
        .bits_i (vld_q),
        .cnt_o  (count_o)
    );

    assign full_o = (count_o == CntW'(Size));

endmodule
